// File: rtl/qpu_gate_executor.sv
// Single-qubit gate executor: 4-deep command FIFO feeding a FETCH/EXEC/MUL/WB FSM
// over real Q2.14 amplitudes. Define QPU_GATE_COUNT_EN to add the gate_count output.
module qpu_gate_executor (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  cmd_gate,
  input  logic        cmd_execute,
  output logic [1:0]  status,
  output logic [31:0] display_alpha,
  output logic [31:0] display_beta,
  output logic        gate_busy
`ifdef QPU_GATE_COUNT_EN
  ,
  output logic [15:0] gate_count
`endif
);

  // state   | meaning
  // S_IDLE  | nothing in flight, waiting for the FIFO to fill
  // S_FETCH | pop FIFO head into gate_q
  // S_EXEC  | single-cycle gates resolved; H forms sum/difference
  // S_MUL   | H only: scale sum/difference by 1/sqrt2
  // S_WB    | commit result to alpha/beta
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MUL, S_WB} state_t;

  localparam logic [2:0] G_H = 3'b001;
  localparam logic [2:0] G_X = 3'b010;
  localparam logic [2:0] G_Z = 3'b011;
  localparam logic [2:0] G_Y = 3'b100;
  localparam logic signed [33:0] H_COEF = 34'sd11585;

  state_t state_q, state_d;

  logic [2:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       ovf_q, done_q;
  logic [2:0] gate_q;

  logic signed [16:0] sum_q, dif_q;
  logic signed [15:0] res_a_q, res_b_q;
  logic signed [15:0] alpha_q, beta_q;

  logic push, pop, full;

  function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
    if (v > 34'sd32767)       return 16'sh7FFF;
    else if (v < -34'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [15:0] neg16(input logic signed [15:0] v);
    return (v == 16'sh8000) ? 16'sh7FFF : -v;
  endfunction

  assign full = (count_q == 3'd4);
  assign pop  = (state_q == S_FETCH);
  assign push = cmd_execute && (!full || pop);

  always_comb begin
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 3'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= cmd_gate;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != 3'd0) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = (gate_q == G_H) ? S_MUL : S_WB;
      S_MUL:   state_d = S_WB;
      S_WB:    state_d = (count_q != 3'd0) ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic signed [16:0] a_ext, b_ext;
  logic signed [15:0] exec_a, exec_b;
  logic signed [33:0] prod_s, prod_d;
  logic signed [33:0] shr_s, shr_d;

  assign a_ext = {alpha_q[15], alpha_q};
  assign b_ext = {beta_q[15], beta_q};

  always_comb begin
    exec_a = alpha_q;
    exec_b = beta_q;
    case (gate_q)
      G_X: begin exec_a = beta_q;         exec_b = alpha_q;        end
      G_Z: begin exec_a = alpha_q;        exec_b = neg16(beta_q);  end
      G_Y: begin exec_a = neg16(beta_q);  exec_b = alpha_q;        end
      default: ;
    endcase
  end

  // Arithmetic shift floors toward -inf, matching the fixed-point rounding intent.
  assign prod_s = $signed({{17{sum_q[16]}}, sum_q}) * H_COEF;
  assign prod_d = $signed({{17{dif_q[16]}}, dif_q}) * H_COEF;
  assign shr_s  = prod_s >>> 14;
  assign shr_d  = prod_d >>> 14;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_q  <= 3'd0;
      sum_q   <= 17'sd0;
      dif_q   <= 17'sd0;
      res_a_q <= 16'sh4000;
      res_b_q <= 16'sh0000;
      alpha_q <= 16'sh4000;
      beta_q  <= 16'sh0000;
    end else begin
      case (state_q)
        S_FETCH: gate_q <= fifo_q[rd_ptr_q];
        S_EXEC: begin
          sum_q   <= a_ext + b_ext;
          dif_q   <= a_ext - b_ext;
          res_a_q <= exec_a;
          res_b_q <= exec_b;
        end
        S_MUL: begin
          res_a_q <= sat16(shr_s);
          res_b_q <= sat16(shr_d);
        end
        S_WB: begin
          alpha_q <= res_a_q;
          beta_q  <= res_b_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (cmd_execute && full && !pop) ovf_q <= 1'b1;
      if (push)                                         done_q <= 1'b0;
      else if (state_q == S_WB && state_d == S_IDLE)    done_q <= 1'b1;
    end
  end

`ifdef QPU_GATE_COUNT_EN
  logic [15:0] gate_count_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              gate_count_q <= 16'd0;
    else if (state_q == S_WB)  gate_count_q <= gate_count_q + 16'd1;
  end
  assign gate_count = gate_count_q;
`endif

  assign gate_busy     = (count_q != 3'd0) || (state_q != S_IDLE);
  assign status        = ovf_q ? 2'b11 : gate_busy ? 2'b01 : done_q ? 2'b10 : 2'b00;
  assign display_alpha = {{16{alpha_q[15]}}, alpha_q};
  assign display_beta  = {{16{beta_q[15]}}, beta_q};

endmodule

// File: tb/tb_qpu_gate_executor.sv
// Scoreboard bench for qpu_gate_executor: a cycle-level model predicts acceptance,
// completion edge and amplitudes of each command; outputs are checked every cycle.
module tb_qpu_gate_executor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  cmd_gate = 3'd0;
  logic        cmd_execute = 1'b0;
  logic [1:0]  status;
  logic [31:0] display_alpha, display_beta;
  logic        gate_busy;
`ifdef QPU_GATE_COUNT_EN
  logic [15:0] gate_count;
`endif

  qpu_gate_executor dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_gate      (cmd_gate),
    .cmd_execute   (cmd_execute),
    .status        (status),
    .display_alpha (display_alpha),
    .display_beta  (display_beta),
    .gate_busy     (gate_busy)
`ifdef QPU_GATE_COUNT_EN
    ,
    .gate_count    (gate_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          a;
    int          p;
    int          u;
    logic [15:0] ea;
    logic [15:0] eb;
  } ent_t;

  ent_t hist[$];
  ent_t pend[$];
  logic [15:0] mdl_a = 16'h4000, mdl_b = 16'h0000;
  logic [15:0] cur_a = 16'h4000, cur_b = 16'h0000;
  int  ncomp = 0;
  bit  ovf = 0;
  int  ovf_edge = 0;
  bit  in_rst = 1;
  int  n_checks = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] m_sat(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [15:0] m_neg(input logic [15:0] x);
    return m_sat(-int'($signed(x)));
  endfunction

  task automatic m_apply(input logic [2:0] g);
    int s, d;
    logic [15:0] na, nb;
    na = mdl_a; nb = mdl_b;
    case (g)
      3'd1: begin
        s  = int'($signed(mdl_a)) + int'($signed(mdl_b));
        d  = int'($signed(mdl_a)) - int'($signed(mdl_b));
        na = m_sat((s * 11585) >>> 14);
        nb = m_sat((d * 11585) >>> 14);
      end
      3'd2: begin na = mdl_b;        nb = mdl_a;        end
      3'd3: begin na = mdl_a;        nb = m_neg(mdl_b); end
      3'd4: begin na = m_neg(mdl_b); nb = mdl_a;        end
      default: ;
    endcase
    mdl_a = na; mdl_b = nb;
  endtask

  // Drive one strobe at the next negedge; the posedge that samples it is edge t.
  task automatic send(input logic [2:0] g);
    int t, f, u_prev, cnt;
    bit pop, acc;
    ent_t e;
    @(negedge clk);
    cmd_gate = g;
    cmd_execute = 1'b1;
    t = cyc + 1;
    u_prev = (hist.size() > 0) ? hist[hist.size()-1].u : -100;
    f = (u_prev > t + 1) ? u_prev : t + 1;
    cnt = 0; pop = 0;
    foreach (hist[i]) begin
      if (hist[i].a < t && hist[i].p >= t) cnt++;
      if (hist[i].p == t) pop = 1;
    end
    acc = (cnt < 4) || pop;
    if (acc) begin
      m_apply(g);
      e.a = t; e.p = f + 1; e.u = f + 3 + ((g == 3'd1) ? 1 : 0);
      e.ea = mdl_a; e.eb = mdl_b;
      hist.push_back(e);
      pend.push_back(e);
    end else if (!ovf) begin
      ovf = 1;
      ovf_edge = t;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_execute = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    in_rst = 1;
    reset_n = 1'b0;
    #1;
    check_val("rst_alpha", display_alpha, 32'h0000_4000);
    check_val("rst_beta", display_beta, 32'h0000_0000);
    check_val("rst_status", {30'd0, status}, 32'd0);
    check_val("rst_busy", {31'd0, gate_busy}, 32'd0);
    hist.delete();
    pend.delete();
    mdl_a = 16'h4000; mdl_b = 16'h0000;
    cur_a = 16'h4000; cur_b = 16'h0000;
    ncomp = 0; ovf = 0;
    #1;
    reset_n = 1'b1;
    in_rst = 0;
  endtask

  always @(negedge clk) begin
    if (!in_rst) begin
      ent_t e;
      bit busy;
      logic [1:0] st;
      while (pend.size() > 0 && pend[0].u <= cyc) begin
        e = pend.pop_front();
        cur_a = e.ea;
        cur_b = e.eb;
        ncomp++;
      end
      busy = 0;
      foreach (hist[i]) if (hist[i].a <= cyc && cyc < hist[i].u) busy = 1;
      st = (ovf && cyc >= ovf_edge) ? 2'b11 : busy ? 2'b01 : (ncomp > 0) ? 2'b10 : 2'b00;
      check_val("alpha", display_alpha, {{16{cur_a[15]}}, cur_a});
      check_val("beta", display_beta, {{16{cur_b[15]}}, cur_b});
      check_val("status", {30'd0, status}, {30'd0, st});
      check_val("busy", {31'd0, gate_busy}, {31'd0, busy});
    end
  end

  initial begin
    apply_reset();
    idle(2);

    send(3'd1);
    idle(7);
    check_val("h1_alpha", display_alpha, 32'h0000_2D41);
    check_val("h1_beta", display_beta, 32'h0000_2D41);
    check_val("h1_status", {30'd0, status}, 32'd2);
    check_val("h1_busy", {31'd0, gate_busy}, 32'd0);

    apply_reset();
    send(3'd1);
    send(3'd1);
    idle(12);
    check_val("hh_alpha", display_alpha, 32'h0000_3FFF);
    check_val("hh_beta", display_beta, 32'h0000_0000);

    apply_reset();
    send(3'd2);
    send(3'd3);
    send(3'd4);
    idle(15);
    check_val("xzy_alpha", display_alpha, 32'h0000_4000);
    check_val("xzy_beta", display_beta, 32'h0000_0000);

    for (int i = 0; i < 24; i++) begin
      send(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
    end
    idle(40);

    apply_reset();
    for (int i = 0; i < 7; i++) send((i % 2 == 0) ? 3'd2 : 3'd3);
    idle(40);
    check_val("ovf_status", {30'd0, status}, 32'd3);
    check_val("ovf_busy", {31'd0, gate_busy}, 32'd0);
    send(3'd2);
    idle(8);
    check_val("ovf_sticky", {30'd0, status}, 32'd3);

    apply_reset();
    send(3'd1);
    idle(3);
    apply_reset();
    idle(10);
    check_val("mul_rst_alpha", display_alpha, 32'h0000_4000);
    check_val("mul_rst_status", {30'd0, status}, 32'd0);

`ifdef QPU_GATE_COUNT_EN
    apply_reset();
    send(3'd2);
    send(3'd0);
    send(3'd3);
    idle(20);
    check_val("gc_three", {16'd0, gate_count}, 32'd3);
    @(negedge clk);
    force dut.gate_count_q = 16'hFFFF;
    #1;
    release dut.gate_count_q;
    send(3'd0);
    idle(8);
    check_val("gc_wrap", {16'd0, gate_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
